// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end for a 64x32 word memory; sub-word stores use
// a two-cycle read-modify-write. Define MISALIGN_TRAP_EN to flag misaligned accesses.
module load_store_unit #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

    state_e            state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_mis_q, resp_mis_d;
    logic [ADDR_W-3:0] rmw_addr_q, rmw_addr_d;
    logic [31:0]       rmw_old_q, rmw_old_d;
    logic [3:0]        rmw_mask_q, rmw_mask_d;
    logic [31:0]       rmw_data_q, rmw_data_d;

    logic        rd_en, wr_en;
    logic [1:0]  size;
    logic        is_b, is_h, is_w;
    logic        legal;
    logic        trap;
    logic [1:0]  off;
    logic [31:0] rd_shift;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic [31:0] mask32;

    assign size = req_funct3[1:0];
    assign is_b = (size == 2'd0);
    assign is_h = (size == 2'd1);
    assign is_w = (size == 2'd2);

    always_comb begin
        legal = 1'b0;
        if (req_we) begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = legal & ((is_h & req_addr[0]) | (is_w & (req_addr[1:0] != 2'b00)));
    assign off  = req_addr[1:0];
`else
    // Without trapping, offending low bits are dropped so the access stays naturally aligned.
    assign trap = 1'b0;
    assign off  = is_w ? 2'b00 : (is_h ? {req_addr[1], 1'b0} : req_addr[1:0]);
`endif

    assign rd_shift = mem_rdata >> {off, 3'b000};

    always_comb begin
        ld_data = rd_shift;
        if (is_b) begin
            ld_data = req_funct3[2] ? {24'b0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
        end else if (is_h) begin
            ld_data = req_funct3[2] ? {16'b0, rd_shift[15:0]} :
                                      {{16{rd_shift[15]}}, rd_shift[15:0]};
        end
    end

    assign st_data = is_b ? {4{req_wdata[7:0]}} : {2{req_wdata[15:0]}};
    assign st_mask = is_b ? (4'b0001 << off) : (off[1] ? 4'b1100 : 4'b0011);

    always_comb begin
        mask32 = '0;
        for (int i = 0; i < 4; i++) begin
            mask32[8*i +: 8] = {8{rmw_mask_q[i]}};
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_mis_d   = 1'b0;
        rmw_addr_d   = rmw_addr_q;
        rmw_old_d    = rmw_old_q;
        rmw_mask_d   = rmw_mask_q;
        rmw_data_d   = rmw_data_q;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        req_ready    = 1'b0;
        mem_addr     = req_addr[ADDR_W-1:2];
        mem_wdata    = req_wdata;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    resp_valid_d = 1'b1;
                    if (!legal || trap) begin
                        resp_mis_d = trap;
                    end else if (!req_we) begin
                        rd_en        = 1'b1;
                        resp_rdata_d = ld_data;
                    end else if (is_w) begin
                        wr_en = 1'b1;
                    end else begin
                        // Sub-word store: fetch the old word now, merge and write next cycle.
                        rd_en        = 1'b1;
                        resp_valid_d = 1'b0;
                        rmw_addr_d   = req_addr[ADDR_W-1:2];
                        rmw_old_d    = mem_rdata;
                        rmw_mask_d   = st_mask;
                        rmw_data_d   = st_data;
                        state_d      = StRmwWr;
                    end
                end
            end
            StRmwWr: begin
                wr_en        = 1'b1;
                mem_addr     = rmw_addr_q;
                mem_wdata    = (rmw_old_q & ~mask32) | (rmw_data_q & mask32);
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset blocks any memory strobe, including a pending read-modify-write.
    assign mem_read  = rd_en & rst_n;
    assign mem_write = wr_en & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            rmw_addr_q   <= '0;
            rmw_old_q    <= '0;
            rmw_mask_q   <= '0;
            rmw_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_old_q    <= rmw_old_d;
            rmw_mask_q   <= rmw_mask_d;
            rmw_data_q   <= rmw_data_d;
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end placed between the execute stage and the 64×32-bit word data memory (`DataMem`). It accepts one RV32I memory request at a time and converts byte/half/word accesses into word accesses. Sub-word stores use a registered two-cycle read-modify-write. Load data is sign- or zero-extended and returned through a one-cycle-registered response.

## Interface
Parameters:
- `ADDR_W`, default 8: byte-address width. Word address is `ADDR_W-2` = 6 bits, matching the 64-word memory.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  reset; synchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; request accepted when `req_valid & req_ready` at a rising edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: `000` B, `001` H, `010` W, `100` BU, `101` HU.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data; low bits used for B/H.
- `resp_valid`  out  1  one-cycle pulse per accepted request.
- `resp_rdata`  out  32  extended load data, valid with `resp_valid`; 0 for stores.
- `resp_misaligned`  out  1  misalignment flag, valid with `resp_valid`.
- `mem_read`  out  1  to `DataMem.MemRead`.
- `mem_write`  out  1  to `DataMem.MemWrite`.
- `mem_addr`  out  6  word address, `req_addr[7:2]` or the latched address.
- `mem_wdata`  out  32  word to write.
- `mem_rdata`  in  32  combinational read data from `DataMem`.

## Operation
- FSM states:
  - `IDLE`: `req_ready` = 1.
  - `RMW_WR`: `req_ready` = 0.
- IDLE, request accepted:
  - Load: `mem_read` = 1. Select the byte or half from `mem_rdata` by `addr[1:0]`. Extend per funct3 (B/H sign, BU/HU zero, W none). Register the result into `resp_rdata`. Stay in IDLE.
  - SW: `mem_write` = 1, `mem_wdata` = `req_wdata`. Stay in IDLE.
  - SB/SH: `mem_read` = 1. Latch `mem_rdata`, the word address, the byte-lane mask and the shifted store data. Go to RMW_WR.
  - Unsupported funct3 (`011`, `110`, `111`, and `100`/`101` with `req_we` = 1): no memory access. `resp_valid` pulses with `resp_rdata` = 0.
- RMW_WR:
  - `mem_write` = 1, `mem_addr` = latched word address.
  - `mem_wdata` = (old & ~mask) | (shifted data & mask).
  - Return to IDLE.
- `mem_read` and `mem_write` are never both 1 in the same cycle.
- Both `mem_read` and `mem_write` are forced to 0 whenever `rst_n` = 0.
- Reset values: state IDLE, `resp_valid` 0, `resp_rdata` 0, `resp_misaligned` 0, latched registers 0. `req_ready` is 1 one cycle after reset release.

## Timing
- Load, SW and unsupported requests: accepted at edge N, `resp_valid` high in cycle N+1 for exactly one cycle.
- Back-to-back loads/SW: one per cycle, full throughput.
- SB/SH: read in the acceptance cycle N, write in cycle N+1 (committed at edge N+1), `resp_valid` in cycle N+2. `req_ready` = 0 during cycle N+1.
- A load to the same word issued right after an SB/SH observes the merged value, because the write commits before that load is accepted.
- Reset asserted while in RMW_WR: no write occurs, FSM goes to IDLE, no `resp_valid` is produced.
- Address wrap: the word index is `addr[7:2]` only; no bounds check is done and 0xFC–0xFF map to word 63.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Misaligned means H/HU/SH with `addr[0]` = 1, or W/SW with `addr[1:0]` ≠ 0.
  - A misaligned request is accepted with no memory access.
  - `resp_valid` pulses next cycle with `resp_misaligned` = 1 and `resp_rdata` = 0.
- `MISALIGN_TRAP_EN` undefined:
  - `resp_misaligned` is tied to 0.
  - Offending low address bits are cleared: H uses `addr[0]` = 0, W uses `addr[1:0]` = 0. The access then proceeds normally.

## Test plan
- Memory preloaded mem[0]=1, mem[1]=2, mem[2]=3. LW addr 0x04 -> `resp_valid` at N+1, `resp_rdata` = 0x00000002, `mem_addr` = 1.
- SB wdata 0x000000AB, addr 0x01 -> `req_ready` low 1 cycle, mem[0] = 0x0000AB01. Then LB 0x01 -> 0xFFFFFFAB, and LBU 0x01 -> 0x000000AB.
- SH wdata 0x00008001, addr 0x0A -> mem[2] = 0x80010003. Then LH 0x0A -> 0xFFFF8001, and LHU 0x0A -> 0x00008001.
- LW addr 0x06:
  - With `MISALIGN_TRAP_EN`: `resp_misaligned` = 1, `resp_rdata` = 0, no `mem_read`.
  - Without it: `resp_rdata` = mem[1] = 0x00000002.
- Accept SB to addr 0x08, then drive `rst_n` = 0 during RMW_WR -> mem[2] unchanged (0x00000003), no `resp_valid`, `req_ready` = 1 one cycle after `rst_n` returns high.
- Back-to-back LW 0x00, 0x04, 0x08 on consecutive cycles -> `resp_valid` high for 3 consecutive cycles with 1, 2, 3.
